dmem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the single-port DATA_MEMORY (sync write, comb read).

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory.
// Optional feature: define DMEM_ARB_ADDR_CHECK_EN to flag out-of-range addresses (addr >= DEPTH).
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 32,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_valid,
    input  logic                  p0_we,
    input  logic [ADD_WIDTH-1:0]  p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    input  logic                  p1_valid,
    input  logic                  p1_we,
    input  logic [ADD_WIDTH-1:0]  p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_we,
    output logic [ADD_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, state_next;
    logic                  rr_last;
    logic                  grant;
    logic                  lat_we;
    logic                  arb_go;
    logic                  arb_win;
    logic                  arb_we;
    logic [ADD_WIDTH-1:0]  arb_addr;
    logic [DATA_WIDTH-1:0] arb_wdata;
    logic                  hit_err;
    logic                  rdata_kill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Arbitration happens from IDLE and RESP; on a tie the port that did not win last time goes.
    always_comb begin
        state_next = state;
        arb_go     = 1'b0;
        arb_win    = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (p0_valid || p1_valid) begin
                    arb_go     = 1'b1;
                    arb_win    = (p0_valid && p1_valid) ? ~rr_last : p1_valid;
                    state_next = ACCESS;
                end else begin
                    state_next = IDLE;
                end
            end
            ACCESS:  state_next = RESP;
            default: state_next = IDLE;
        endcase
        arb_we    = arb_win ? p1_we    : p0_we;
        arb_addr  = arb_win ? p1_addr  : p0_addr;
        arb_wdata = arb_win ? p1_wdata : p0_wdata;
    end

`ifdef DMEM_ARB_ADDR_CHECK_EN
    localparam logic [ADD_WIDTH-1:0] DEPTH_LIM = ADD_WIDTH'(DEPTH);

    logic lat_err;

    assign hit_err    = (arb_addr >= DEPTH_LIM);
    assign rdata_kill = lat_we | lat_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_err <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            if (arb_go) lat_err <= hit_err;
            rsp_err <= (state == ACCESS) ? lat_err : 1'b0;
        end
    end
`else
    assign hit_err    = 1'b0;
    assign rdata_kill = lat_we;
    assign rsp_err    = 1'b0;
`endif

    // mem_addr/mem_wdata double as the latched request and simply hold between accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last   <= 1'b1;
            grant     <= 1'b0;
            lat_we    <= 1'b0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            busy      <= (state_next != IDLE);
            if (arb_go) begin
                grant     <= arb_win;
                rr_last   <= arb_win;
                lat_we    <= arb_we;
                mem_addr  <= arb_addr;
                mem_wdata <= arb_wdata;
                mem_we    <= arb_we & ~hit_err;
                p0_ack    <= ~arb_win;
                p1_ack    <= arb_win;
            end
            if (state == ACCESS) begin
                rsp_valid <= grant ? 2'b10 : 2'b01;
                rsp_rdata <= rdata_kill ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural sync-write/comb-read memory.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p0_we, p1_valid, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    logic [31:0] tb_mem [0:255];
    int          total = 0;
    int          bad = 0;
    int          pulses = 0;
    bit          count_en = 1'b0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = tb_mem[mem_addr[7:0]];

    always @(negedge clk) begin
        if (count_en && rsp_valid != 2'b00) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(int port, logic we, logic [31:0] addr, logic [31:0] wdata);
        if (port == 0) begin
            p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic idle_ports();
        p0_valid = 1'b0;
        p1_valid = 1'b0;
    endtask

    // One complete single-requester transaction with checks in ACCESS, RESP and the following IDLE.
    task automatic single_access(string tag, int port, logic we, logic [31:0] addr, logic [31:0] wdata,
                                 logic [31:0] exp_rdata, logic exp_err);
        apply_stimulus(port, we, addr, wdata);
        tick();
        check_output({tag, ".ack"}, {p1_ack, p0_ack}, (port == 0) ? 2'b01 : 2'b10);
        check_output({tag, ".mem_we"}, mem_we, we & ~exp_err);
        check_output({tag, ".mem_addr"}, mem_addr, addr);
        check_output({tag, ".busy_acc"}, busy, 1'b1);
        idle_ports();
        tick();
        check_output({tag, ".rsp_valid"}, rsp_valid, (port == 0) ? 2'b01 : 2'b10);
        check_output({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        check_output({tag, ".rsp_err"}, rsp_err, exp_err);
        check_output({tag, ".ack_off"}, {p1_ack, p0_ack}, 2'b00);
        check_output({tag, ".mem_we_off"}, mem_we, 1'b0);
        tick();
        check_output({tag, ".busy_idle"}, busy, 1'b0);
        check_output({tag, ".rsp_idle"}, rsp_valid, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

        // Reset and idle behaviour, with reset released mid-cycle
        tick();
        tick();
        check_output("rst.outputs", {p0_ack, p1_ack, rsp_valid, rsp_err, mem_we, busy}, 7'b0);
        check_output("rst.mem_addr", mem_addr, 32'h0);
        check_output("rst.rsp_rdata", rsp_rdata, 32'h0);
        #3 reset = 1'b0;
        #1 check_output("rst.release_we", mem_we, 1'b0);
        tick();
        tick();
        check_output("idle.outputs", {p0_ack, p1_ack, rsp_valid, mem_we, busy}, 6'b0);

        // p0 write then p1 read-back
        single_access("wr5", 0, 1'b1, 32'd5, 32'hDEADBEEF, 32'h0, 1'b0);
        single_access("rd5", 1, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0);

        // Preload through port 1 so the next tie goes to port 0
        single_access("pre1", 1, 1'b1, 32'd1, 32'h0000_0111, 32'h0, 1'b0);
        single_access("pre2", 1, 1'b1, 32'd2, 32'h0000_0222, 32'h0, 1'b0);

        // Both ports hold reads: grants must alternate 0,1,0,1...
        apply_stimulus(0, 1'b0, 32'd1, 32'h0);
        apply_stimulus(1, 1'b0, 32'd2, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_output($sformatf("rr%0d.ack", i), {p1_ack, p0_ack}, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check_output($sformatf("rr%0d.rsp", i), rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
            check_output($sformatf("rr%0d.rdata", i), rsp_rdata, (i % 2 == 0) ? 32'h111 : 32'h222);
            check_output($sformatf("rr%0d.noack", i), {p1_ack, p0_ack}, 2'b00);
        end
        idle_ports();
        tick();
        check_output("rr.busy_idle", busy, 1'b0);

        // Reset asserted inside ACCESS of a p1 write must kill the write at once
        single_access("pre7", 1, 1'b1, 32'd7, 32'h11, 32'h0, 1'b0);
        apply_stimulus(1, 1'b1, 32'd7, 32'h55);
        tick();
        check_output("rstacc.ack", p1_ack, 1'b1);
        check_output("rstacc.we_before", mem_we, 1'b1);
        #2 reset = 1'b1;
        #1 check_output("rstacc.we_now", mem_we, 1'b0);
        check_output("rstacc.ack_now", {p1_ack, p0_ack}, 2'b00);
        idle_ports();
        tick();
        check_output("rstacc.no_rsp", rsp_valid, 2'b00);
        check_output("rstacc.busy", busy, 1'b0);
        #3 reset = 1'b0;
        tick();
        single_access("rd7", 0, 1'b0, 32'd7, 32'h0, 32'h11, 1'b0);

        // Address beyond DEPTH
        single_access("oob200", 0, 1'b1, 32'd200, 32'hAA, 32'h0, CHK);

        // p0 holds valid after ack: re-granted at end of RESP, exactly two responses
        single_access("pre3", 0, 1'b1, 32'd3, 32'h333, 32'h0, 1'b0);
        count_en = 1'b1;
        apply_stimulus(0, 1'b0, 32'd3, 32'h0);
        tick();
        check_output("hold.ack1", p0_ack, 1'b1);
        tick();
        check_output("hold.rsp1", rsp_valid, 2'b01);
        check_output("hold.rdata1", rsp_rdata, 32'h333);
        tick();
        check_output("hold.ack2", p0_ack, 1'b1);
        idle_ports();
        tick();
        check_output("hold.rsp2", rsp_valid, 2'b01);
        check_output("hold.rdata2", rsp_rdata, 32'h333);
        tick();
        tick();
        tick();
        count_en = 1'b0;
        check_output("hold.pulses", pulses, 2);
        check_output("hold.busy_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
